// File: rtl/uart_rx_packet_parser.sv
// rtl/uart_rx_packet_parser.sv - frames SYNC/LEN/payload/CHK packets from a UART byte stream
module uart_rx_packet_parser #(
    parameter int           MAX_LEN      = 16,
    parameter int           ADDR_W       = 4,
    parameter logic [7:0]   SYNC_BYTE    = 8'hA5,
    parameter int           TIMEOUT_CLKS = 100000
) (
    input  logic              i_Clock,
    input  logic              reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Pkt_Valid,
    output logic [7:0]        o_Pkt_Len,
    input  logic              i_Pkt_Ack,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data,
    output logic              o_Len_Err,
    output logic              o_Chk_Err,
    output logic              o_Timeout_Err,
    output logic              o_Overrun
);

    typedef enum logic [2:0] {HUNT, GET_LEN, GET_PAY, GET_CHK, HOLD} state_t;

    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CLKS - 1);

    state_t      r_State, w_Next;
    logic [7:0]  r_Len, r_Chk, r_Idx, r_Pkt_Len, r_Rd_Data;
    logic [31:0] r_Tmo_Cnt;
    logic        r_Pkt_Valid, r_Len_Err, r_Chk_Err, r_Tmo_Err, r_Overrun;
    logic [7:0]  r_Buf [0:(2**ADDR_W)-1];

    logic w_In_Frame, w_Tmo, w_Len_Bad;
    logic w_Len_Err, w_Chk_Err, w_Tmo_Err, w_Overrun;
    logic w_Len_Ok, w_Pay_Wr, w_Accept, w_Release;

    assign w_In_Frame = (r_State == GET_LEN) || (r_State == GET_PAY) || (r_State == GET_CHK);
    // A byte arriving in the expiry cycle takes precedence over the timeout
    assign w_Tmo      = w_In_Frame && !i_Rx_DV && (r_Tmo_Cnt == TMO_LAST);
    assign w_Len_Bad  = (i_Rx_Byte == 8'h00) || (i_Rx_Byte > MAX_LEN_B);

    always_ff @(posedge i_Clock) begin
        if (reset) r_State <= HUNT;
        else       r_State <= w_Next;
    end

    always_comb begin
        w_Next = r_State;
        case (r_State)
            HUNT:    if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) w_Next = GET_LEN;
            GET_LEN: if (i_Rx_DV)   w_Next = w_Len_Bad ? HUNT : GET_PAY;
                     else if (w_Tmo) w_Next = HUNT;
            GET_PAY: if (i_Rx_DV) begin
                         if (r_Idx == r_Len - 8'd1) w_Next = GET_CHK;
                     end else if (w_Tmo) w_Next = HUNT;
            GET_CHK: if (i_Rx_DV)   w_Next = (i_Rx_Byte == r_Chk) ? HOLD : HUNT;
                     else if (w_Tmo) w_Next = HUNT;
            HOLD:    if (i_Pkt_Ack) w_Next = HUNT;
            default: w_Next = HUNT;
        endcase
    end

    always_comb begin
        w_Len_Err = 1'b0;
        w_Chk_Err = 1'b0;
        w_Tmo_Err = w_Tmo;
        w_Overrun = 1'b0;
        w_Len_Ok  = 1'b0;
        w_Pay_Wr  = 1'b0;
        w_Accept  = 1'b0;
        w_Release = 1'b0;
        case (r_State)
            GET_LEN: begin
                w_Len_Err = i_Rx_DV && w_Len_Bad;
                w_Len_Ok  = i_Rx_DV && !w_Len_Bad;
            end
            GET_PAY: w_Pay_Wr = i_Rx_DV;
            GET_CHK: begin
                w_Accept  = i_Rx_DV && (i_Rx_Byte == r_Chk);
                w_Chk_Err = i_Rx_DV && (i_Rx_Byte != r_Chk);
            end
            HOLD: begin
                w_Overrun = i_Rx_DV;
                w_Release = i_Pkt_Ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            r_Len       <= 8'h00;
            r_Chk       <= 8'h00;
            r_Idx       <= 8'h00;
            r_Tmo_Cnt   <= 32'd0;
            r_Pkt_Valid <= 1'b0;
            r_Pkt_Len   <= 8'h00;
            r_Rd_Data   <= 8'h00;
            r_Len_Err   <= 1'b0;
            r_Chk_Err   <= 1'b0;
            r_Tmo_Err   <= 1'b0;
            r_Overrun   <= 1'b0;
        end else begin
            r_Len_Err <= w_Len_Err;
            r_Chk_Err <= w_Chk_Err;
            r_Tmo_Err <= w_Tmo_Err;
            r_Overrun <= w_Overrun;
            if (i_Rx_DV || !w_In_Frame) r_Tmo_Cnt <= 32'd0;
            else                        r_Tmo_Cnt <= r_Tmo_Cnt + 32'd1;
            if (w_Len_Ok) begin
                r_Len <= i_Rx_Byte;
                r_Chk <= i_Rx_Byte;
                r_Idx <= 8'h00;
            end
            if (w_Pay_Wr) begin
                r_Chk <= r_Chk ^ i_Rx_Byte;
                r_Idx <= r_Idx + 8'd1;
            end
            if (w_Accept) begin
                r_Pkt_Valid <= 1'b1;
                r_Pkt_Len   <= r_Len;
            end else if (w_Release) begin
                r_Pkt_Valid <= 1'b0;
            end
            r_Rd_Data <= (9'(i_Rd_Addr) < {1'b0, r_Pkt_Len}) ? r_Buf[i_Rd_Addr] : 8'h00;
        end
    end

    // Payload storage is deliberately left out of reset
    always_ff @(posedge i_Clock) begin
        if (w_Pay_Wr) r_Buf[r_Idx[ADDR_W-1:0]] <= i_Rx_Byte;
    end

    assign o_Pkt_Valid   = r_Pkt_Valid;
    assign o_Pkt_Len     = r_Pkt_Len;
    assign o_Rd_Data     = r_Rd_Data;
    assign o_Len_Err     = r_Len_Err;
    assign o_Chk_Err     = r_Chk_Err;
    assign o_Timeout_Err = r_Tmo_Err;
    assign o_Overrun     = r_Overrun;

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// tb/tb_uart_rx_packet_parser.sv - randomized self-checking bench for uart_rx_packet_parser
module tb_uart_rx_packet_parser;

    localparam int TMO = 50;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dv = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       ack = 1'b0;
    logic [3:0] addr = 4'h0;
    logic       pkt_valid, len_err, chk_err, tmo_err, overrun;
    logic [7:0] pkt_len, rd_data;

    always #5 clk = ~clk;

    uart_rx_packet_parser #(
        .MAX_LEN(MAXL), .ADDR_W(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)
    ) dut (
        .i_Clock(clk), .reset(reset), .i_Rx_DV(dv), .i_Rx_Byte(byte_in),
        .o_Pkt_Valid(pkt_valid), .o_Pkt_Len(pkt_len), .i_Pkt_Ack(ack),
        .i_Rd_Addr(addr), .o_Rd_Data(rd_data), .o_Len_Err(len_err),
        .o_Chk_Err(chk_err), .o_Timeout_Err(tmo_err), .o_Overrun(overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame contents collected as a queue of LEN + payload bytes
    bit         m_in_frame, m_held;
    logic [7:0] m_q [$];
    int         m_idle;
    logic [7:0] m_len;
    logic [7:0] m_pay [16];

    task automatic model_reset();
        m_in_frame = 0;
        m_held = 0;
        m_q.delete();
        m_idle = 0;
        m_len = 8'h00;
    endtask

    task automatic step(input bit d, input logic [7:0] b, input bit a);
        bit e_len, e_chk, e_tmo, e_ovr, rd_chk;
        logic [7:0] rd_exp, x;
        e_len = 0; e_chk = 0; e_tmo = 0; e_ovr = 0;
        rd_chk = m_held;
        rd_exp = ({4'h0, addr} < m_len) ? m_pay[addr] : 8'h00;
        if (m_held) begin
            if (d) e_ovr = 1;
            if (a) m_held = 0;
        end else if (!m_in_frame) begin
            if (d && b == 8'hA5) begin
                m_in_frame = 1;
                m_q.delete();
                m_idle = 0;
            end
        end else if (d) begin
            m_idle = 0;
            if (m_q.size() == 0) begin
                if (b == 8'h00 || int'(b) > MAXL) begin
                    e_len = 1;
                    m_in_frame = 0;
                end else m_q.push_back(b);
            end else if (m_q.size() == int'(m_q[0]) + 1) begin
                x = 8'h00;
                foreach (m_q[i]) x ^= m_q[i];
                if (x == b) begin
                    m_held = 1;
                    m_len = m_q[0];
                    for (int i = 0; i < int'(m_q[0]); i++) m_pay[i] = m_q[i+1];
                end else e_chk = 1;
                m_in_frame = 0;
            end else m_q.push_back(b);
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                e_tmo = 1;
                m_in_frame = 0;
            end
        end
        dv = d; byte_in = b; ack = a;
        @(posedge clk); #1;
        check("pkt_valid", 32'(pkt_valid), 32'(m_held));
        if (m_held) check("pkt_len", 32'(pkt_len), 32'(m_len));
        check("len_err", 32'(len_err), 32'(e_len));
        check("chk_err", 32'(chk_err), 32'(e_chk));
        check("timeout_err", 32'(tmo_err), 32'(e_tmo));
        check("overrun", 32'(overrun), 32'(e_ovr));
        if (rd_chk) check("rd_data", 32'(rd_data), 32'(rd_exp));
        addr = addr + 4'h1;
    endtask

    task automatic do_reset();
        reset = 1; dv = 0; ack = 0;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_len", 32'(pkt_len), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        check("rst_errs", {28'd0, len_err, chk_err, tmo_err, overrun}, 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        step(1, b, 0);
    endtask

    task automatic idle(input int n, input bit allow_ack);
        for (int i = 0; i < n; i++)
            step(0, 8'h00, allow_ack && m_held && ($urandom_range(0, 3) == 0));
    endtask

    task automatic send_good(input int n);
        logic [7:0] x, v;
        x = 8'(n);
        send(8'hA5);
        send(8'(n));
        for (int i = 0; i < n; i++) begin
            v = 8'($urandom);
            x ^= v;
            send(v);
        end
        send(x);
    endtask

    initial begin
        logic [7:0] seq [];
        int kind, n;
        model_reset();
        do_reset();

        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        foreach (seq[i]) send(seq[i]);
        idle(20, 0);
        send(8'h5A); send(8'hA5);
        step(1, 8'h77, 1);
        idle(20, 0);

        seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31, 8'hA5, 8'h01, 8'h55, 8'h54};
        foreach (seq[i]) send(seq[i]);
        idle(16, 0);
        step(0, 8'h00, 1);

        seq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'hA5};
        foreach (seq[i]) send(seq[i]);
        idle(3, 0);

        seq = '{8'hA5, 8'h04, 8'h01};
        foreach (seq[i]) send(seq[i]);
        idle(60, 0);
        send_good(2);
        idle(4, 0);
        step(0, 8'h00, 1);

        seq = '{8'hA5, 8'h03, 8'hAA};
        foreach (seq[i]) send(seq[i]);
        do_reset();
        idle(2, 0);
        send_good(3);
        idle(5, 0);
        do_reset();

        for (int p = 0; p < 300; p++) begin
            kind = $urandom_range(0, 5);
            n = $urandom_range(1, MAXL);
            case (kind)
                0: send(8'($urandom));
                1, 5: send_good(n);
                2: begin
                    send(8'hA5); send(8'(n));
                    for (int i = 0; i < n; i++) send(8'($urandom));
                    send(8'($urandom));
                end
                3: begin
                    send(8'hA5);
                    send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
                end
                default: begin
                    send(8'hA5); send(8'(n));
                    idle($urandom_range(TMO - 2, TMO + 5), 1);
                end
            endcase
            idle($urandom_range(0, 6), 1);
            if ($urandom_range(0, 40) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
